// File: rtl/board_cursor_ctrl.sv
// Board cursor controller: turns held direction buttons into single-cell steps
// with auto-repeat, clamp or wrap at the edges, plus load/home jumps.
//
// state    | meaning
// S_IDLE   | no button held; a held button steps at once and arms the delay
// S_DELAY  | button held, waiting REPEAT_DELAY cycles for the first repeat
// S_REPEAT | button held, stepping every REPEAT_RATE cycles
module board_cursor_ctrl #(
  parameter int BOARD_W      = 8,
  parameter int BOARD_H      = 8,
  parameter int COORD_W      = 3,
  parameter bit WRAP         = 1'b0,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int HOME_X       = 3,
  parameter int HOME_Y       = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               moveRightEn,
  input  logic               moveLeftEn,
  input  logic               moveUpEn,
  input  logic               moveDownEn,
  input  logic               homeEn,
  input  logic               loadEn,
  input  logic [COORD_W-1:0] loadX,
  input  logic [COORD_W-1:0] loadY,
  output logic [COORD_W-1:0] curX,
  output logic [COORD_W-1:0] curY,
  output logic [COORD_W-1:0] oldX,
  output logic [COORD_W-1:0] oldY,
  output logic               moved,
  output logic               bump
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  localparam logic [CNT_W-1:0]   DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]   RATE_TC  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [COORD_W-1:0] MAX_X    = COORD_W'(BOARD_W - 1);
  localparam logic [COORD_W-1:0] MAX_Y    = COORD_W'(BOARD_H - 1);
  localparam logic [COORD_W-1:0] HOME_XC  = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0] HOME_YC  = COORD_W'(HOME_Y);
  localparam logic [COORD_W:0]   W_EXT    = (COORD_W+1)'(BOARD_W);
  localparam logic [COORD_W:0]   H_EXT    = (COORD_W+1)'(BOARD_H);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0] old_x_q, old_x_d, old_y_q, old_y_d;
  logic               moved_q, moved_d, bump_q, bump_d;

  logic               any_btn, step, refused;
  logic [COORD_W-1:0] step_x, step_y, tgt_x, tgt_y, sat_x, sat_y;

  assign any_btn = moveRightEn | moveLeftEn | moveUpEn | moveDownEn;
  assign sat_x   = ({1'b0, loadX} >= W_EXT) ? MAX_X : loadX;
  assign sat_y   = ({1'b0, loadY} >= H_EXT) ? MAX_Y : loadY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_btn) begin
          step    = 1'b1;
          state_d = S_DELAY;
          cnt_d   = '0;
        end
      end
      S_DELAY: begin
        if (!any_btn) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DELAY_TC) begin
          step    = 1'b1;
          state_d = S_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (!any_btn) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RATE_TC) begin
          step  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // load/home win over any step due this cycle and restart the press logic
    if (loadEn || homeEn) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Edge handling compares against the board limits, so non-power-of-two
  // boards wrap at BOARD_W/BOARD_H rather than at 2^COORD_W.
  always_comb begin
    step_x  = cur_x_q;
    step_y  = cur_y_q;
    refused = 1'b0;
    if (moveRightEn) begin
      if (cur_x_q == MAX_X) begin
        if (WRAP) step_x = '0;
        else      refused = 1'b1;
      end else begin
        step_x = cur_x_q + 1'b1;
      end
    end else if (moveLeftEn) begin
      if (cur_x_q == '0) begin
        if (WRAP) step_x = MAX_X;
        else      refused = 1'b1;
      end else begin
        step_x = cur_x_q - 1'b1;
      end
    end else if (moveUpEn) begin
      if (cur_y_q == '0) begin
        if (WRAP) step_y = MAX_Y;
        else      refused = 1'b1;
      end else begin
        step_y = cur_y_q - 1'b1;
      end
    end else if (moveDownEn) begin
      if (cur_y_q == MAX_Y) begin
        if (WRAP) step_y = '0;
        else      refused = 1'b1;
      end else begin
        step_y = cur_y_q + 1'b1;
      end
    end
  end

  always_comb begin
    tgt_x  = cur_x_q;
    tgt_y  = cur_y_q;
    bump_d = 1'b0;
    if (loadEn) begin
      tgt_x = sat_x;
      tgt_y = sat_y;
    end else if (homeEn) begin
      tgt_x = HOME_XC;
      tgt_y = HOME_YC;
    end else if (step) begin
      tgt_x  = step_x;
      tgt_y  = step_y;
      bump_d = refused;
    end
    moved_d = (tgt_x != cur_x_q) || (tgt_y != cur_y_q);
    cur_x_d = tgt_x;
    cur_y_d = tgt_y;
    old_x_d = moved_d ? cur_x_q : old_x_q;
    old_y_d = moved_d ? cur_y_q : old_y_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_x_q <= HOME_XC;
      cur_y_q <= HOME_YC;
      old_x_q <= HOME_XC;
      old_y_q <= HOME_YC;
      moved_q <= 1'b0;
      bump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      old_x_q <= old_x_d;
      old_y_q <= old_y_d;
      moved_q <= moved_d;
      bump_q  <= bump_d;
    end
  end

  assign curX  = cur_x_q;
  assign curY  = cur_y_q;
  assign oldX  = old_x_q;
  assign oldY  = old_y_q;
  assign moved = moved_q;
  assign bump  = bump_q;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Directed bench for board_cursor_ctrl: a clamped 8x8 instance and a wrapping
// 6x8 instance, checked against hand-computed cursor states.
module tb_board_cursor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       c_r, c_l, c_u, c_d, c_home, c_load;
  logic [3:0] c_lx, c_ly, c_x, c_y, c_ox, c_oy;
  logic       c_moved, c_bump;
  logic       w_r, w_l, w_u, w_d, w_home, w_load;
  logic [2:0] w_lx, w_ly, w_x, w_y, w_ox, w_oy;
  logic       w_moved, w_bump;

  int tests = 0;
  int fails = 0;

  board_cursor_ctrl #(
    .BOARD_W(8), .BOARD_H(8), .COORD_W(4), .WRAP(1'b0),
    .REPEAT_DELAY(4), .REPEAT_RATE(2), .HOME_X(3), .HOME_Y(3)
  ) u_clamp (
    .clk(clk), .resetn(resetn),
    .moveRightEn(c_r), .moveLeftEn(c_l), .moveUpEn(c_u), .moveDownEn(c_d),
    .homeEn(c_home), .loadEn(c_load), .loadX(c_lx), .loadY(c_ly),
    .curX(c_x), .curY(c_y), .oldX(c_ox), .oldY(c_oy),
    .moved(c_moved), .bump(c_bump)
  );

  board_cursor_ctrl #(
    .BOARD_W(6), .BOARD_H(8), .COORD_W(3), .WRAP(1'b1),
    .REPEAT_DELAY(4), .REPEAT_RATE(2), .HOME_X(3), .HOME_Y(3)
  ) u_wrap (
    .clk(clk), .resetn(resetn),
    .moveRightEn(w_r), .moveLeftEn(w_l), .moveUpEn(w_u), .moveDownEn(w_d),
    .homeEn(w_home), .loadEn(w_load), .loadX(w_lx), .loadY(w_ly),
    .curX(w_x), .curY(w_y), .oldX(w_ox), .oldY(w_oy),
    .moved(w_moved), .bump(w_bump)
  );

  function automatic logic [31:0] pk(input logic m, input logic b,
                                     input logic [3:0] x, input logic [3:0] y,
                                     input logic [3:0] ox, input logic [3:0] oy);
    return {14'b0, m, b, x, y, ox, oy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ex, eox;
    logic       stp, bmp;
    resetn = 1'b0;
    {c_r, c_l, c_u, c_d, c_home, c_load} = '0;
    {w_r, w_l, w_u, w_d, w_home, w_load} = '0;
    c_lx = '0; c_ly = '0; w_lx = '0; w_ly = '0;
    #12;
    check("reset_clamp", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 3, 3, 3, 3));
    check("reset_wrap",  pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(0, 0, 3, 3, 3, 3));

    // single press
    resetn = 1'b1;
    c_r = 1'b1;
    tick;
    c_r = 1'b0;
    check("press_right", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 4, 3, 3, 3));
    tick;
    check("press_pulse_end", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 4, 3, 3, 3));

    // auto-repeat from (0,0)
    c_load = 1'b1; c_lx = 4'd0; c_ly = 4'd0;
    tick;
    c_load = 1'b0;
    check("load_origin", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 0, 0, 4, 3));
    ex = 4'd0; eox = 4'd4;
    c_r = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick;
      stp = (i == 0) || (i >= 4 && (i % 2) == 0);
      if (stp) begin
        eox = ex;
        ex  = ex + 4'd1;
      end
      check($sformatf("repeat_c%0d", i), pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy),
            pk(stp, 0, ex, 0, eox, stp ? 4'd0 : (i == 0 ? 4'd3 : 4'd0)));
    end
    c_r = 1'b0;
    tick;
    check("repeat_release", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 5, 0, 4, 0));

    // clamp at left edge
    c_load = 1'b1; c_lx = 4'd0; c_ly = 4'd5;
    tick;
    c_load = 1'b0;
    check("load_0_5", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 0, 5, 5, 0));
    c_l = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick;
      bmp = (i == 0) || (i == 4) || (i == 6);
      check($sformatf("clamp_c%0d", i), pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy),
            pk(0, bmp, 0, 5, 5, 0));
    end
    c_l = 1'b0;
    tick;
    check("clamp_release", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 0, 5, 5, 0));

    // wrap on a 6-wide board
    w_load = 1'b1; w_lx = 3'd5; w_ly = 3'd2;
    tick;
    w_load = 1'b0;
    check("wrap_load_5_2", pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(1, 0, 5, 2, 3, 3));
    w_r = 1'b1;
    tick;
    w_r = 1'b0;
    check("wrap_right", pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(1, 0, 0, 2, 5, 2));
    tick;
    w_l = 1'b1;
    tick;
    w_l = 1'b0;
    check("wrap_left", pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(1, 0, 5, 2, 0, 2));
    tick;
    w_load = 1'b1; w_lx = 3'd1; w_ly = 3'd0;
    tick;
    w_load = 1'b0;
    check("wrap_load_1_0", pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(1, 0, 1, 0, 5, 2));
    w_u = 1'b1;
    tick;
    w_u = 1'b0;
    check("wrap_up", pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(1, 0, 1, 7, 1, 0));
    tick;
    w_load = 1'b1; w_lx = 3'd7; w_ly = 3'd7;
    tick;
    w_load = 1'b0;
    check("wrap_load_sat", pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(1, 0, 5, 7, 1, 7));
    w_d = 1'b1;
    tick;
    w_d = 1'b0;
    check("wrap_down", pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(1, 0, 5, 0, 5, 7));
    tick;

    // home, priority, load colliding with a due repeat
    c_home = 1'b1;
    tick;
    c_home = 1'b0;
    check("home", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 3, 3, 0, 5));
    c_home = 1'b1;
    tick;
    c_home = 1'b0;
    check("home_same_cell", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 3, 3, 0, 5));
    c_r = 1'b1; c_d = 1'b1;
    tick;
    c_r = 1'b0; c_d = 1'b0;
    check("prio_right_down", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 4, 3, 3, 3));
    tick;
    c_r = 1'b1;
    tick;
    check("coll_c0", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 5, 3, 4, 3));
    for (int i = 1; i < 4; i++) begin
      tick;
      check($sformatf("coll_c%0d", i), pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy),
            pk(0, 0, 5, 3, 4, 3));
    end
    c_load = 1'b1; c_lx = 4'd9; c_ly = 4'd2;
    tick;
    c_load = 1'b0;
    check("coll_load", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 7, 2, 5, 3));
    tick;
    check("coll_new_press", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 1, 7, 2, 5, 3));
    c_r = 1'b0;
    tick;
    check("coll_release", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 7, 2, 5, 3));

    // reset in the middle of a hold
    c_home = 1'b1;
    tick;
    c_home = 1'b0;
    check("home_again", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 3, 3, 7, 2));
    c_r = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    check("hold_before_rst", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 5, 3, 4, 3));
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_clamp", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 3, 3, 3, 3));
    check("async_rst_wrap",  pk(w_moved, w_bump, w_x, w_y, w_ox, w_oy), pk(0, 0, 3, 3, 3, 3));
    resetn = 1'b1;
    tick;
    check("press_after_rst", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(1, 0, 4, 3, 3, 3));
    c_r = 1'b0;
    tick;
    check("final_idle", pk(c_moved, c_bump, c_x, c_y, c_ox, c_oy), pk(0, 0, 4, 3, 3, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
